rc4_decrypt_seq: RTL and testbench

Sequencer that drives the RC4 byte-XOR core during image decryption. It fetches 32-bit ciphertext words and requests one keystream byte per pixel from the PRGA. It steps the core through byte indices 0..3 with a one-cycle XOR strobe, reassembles the four plaintext bytes into a word and hands it to the pixel write stage. It sits between the ciphertext SRAM reader, the PRGA and the Sobel input buffer.

---
 rtl/rc4_decrypt_seq_if.sv | 30 +++
 rtl/rc4_decrypt_seq.sv | 109 ++++++++++
 tb/tb_rc4_decrypt_seq.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_decrypt_seq_if.sv
// Bus bundle between the RC4 decrypt sequencer and its neighbours: ciphertext
// reader, PRGA keystream source, byte-XOR core and pixel write stage.
interface rc4_decrypt_seq_if;
  logic        word_valid_i;
  logic [31:0] word_i;
  logic        word_ready_o;
  logic        ks_req_o;
  logic        ks_valid_i;
  logic [7:0]  ks_byte_i;
  logic [31:0] core_word_o;
  logic [7:0]  core_ks_o;
  logic        core_xor_o;
  logic [1:0]  core_idx_o;
  logic [7:0]  core_data_i;
  logic        out_valid_o;
  logic [31:0] out_word_o;
  logic        out_ready_i;

  modport master (
    input  word_valid_i, word_i, ks_valid_i, ks_byte_i, core_data_i, out_ready_i,
    output word_ready_o, ks_req_o, core_word_o, core_ks_o, core_xor_o, core_idx_o,
           out_valid_o, out_word_o
  );

  modport slave (
    output word_valid_i, word_i, ks_valid_i, ks_byte_i, core_data_i, out_ready_i,
    input  word_ready_o, ks_req_o, core_word_o, core_ks_o, core_xor_o, core_idx_o,
           out_valid_o, out_word_o
  );
endinterface

// File: rtl/rc4_decrypt_seq.sv
// RC4 decrypt sequencer: fetches ciphertext words, pulls one keystream byte per
// pixel, strobes the XOR core per byte and reassembles plaintext words.
module rc4_decrypt_seq #(
  parameter logic [19:0] PIXEL_COUNT = 20'd307200
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start_i,
  rc4_decrypt_seq_if.master  bus,
  output logic [19:0]        pix_num_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_KSREQ, S_XOR, S_WRITE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] core_word_q;
  logic [7:0]  core_ks_q;
  logic [1:0]  idx_q;
  logic [31:0] out_word_q;
  logic [19:0] pix_num_q;
  logic [19:0] pix_next;
  logic        last_byte;

  assign pix_next  = pix_num_q + 20'd1;
  // A word closes either when its fourth byte is done or the job runs out of pixels.
  assign last_byte = (pix_next == PIXEL_COUNT) || (idx_q == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)          state_d = S_FETCH;
      S_FETCH: if (bus.word_valid_i) state_d = S_KSREQ;
      S_KSREQ: if (bus.ks_valid_i)   state_d = S_XOR;
      S_XOR:   state_d = last_byte ? S_WRITE : S_KSREQ;
      S_WRITE: if (bus.out_ready_i)
                 state_d = (pix_num_q == PIXEL_COUNT) ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.word_ready_o = 1'b0;
    bus.ks_req_o     = 1'b0;
    bus.core_xor_o   = 1'b0;
    bus.out_valid_o  = 1'b0;
    done_o           = 1'b0;
    busy_o           = (state_q != S_IDLE);
    case (state_q)
      S_FETCH: bus.word_ready_o = 1'b1;
      S_KSREQ: bus.ks_req_o     = 1'b1;
      S_XOR:   bus.core_xor_o   = 1'b1;
      S_WRITE: bus.out_valid_o  = 1'b1;
      S_DONE:  done_o           = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      core_word_q <= '0;
      core_ks_q   <= '0;
      idx_q       <= '0;
      out_word_q  <= '0;
      pix_num_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          pix_num_q  <= '0;
          idx_q      <= '0;
          out_word_q <= '0;
        end
        S_FETCH: if (bus.word_valid_i) core_word_q <= bus.word_i;
        S_KSREQ: if (bus.ks_valid_i)   core_ks_q   <= bus.ks_byte_i;
        S_XOR: begin
          // Byte 0 lives in [31:24], so byte index i maps to bit offset 8*(3-i).
          out_word_q[{~idx_q, 3'b000} +: 8] <= bus.core_data_i;
          pix_num_q <= pix_next;
          if (!last_byte) idx_q <= idx_q + 2'd1;
        end
        S_WRITE: if (bus.out_ready_i) begin
          idx_q      <= '0;
          out_word_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.core_word_o = core_word_q;
  assign bus.core_ks_o   = core_ks_q;
  assign bus.core_idx_o  = idx_q;
  assign bus.out_word_o  = out_word_q;
  assign pix_num_o       = pix_num_q;

endmodule

// File: tb/tb_rc4_decrypt_seq.sv
// Self-checking bench for rc4_decrypt_seq: two instances (4 and 6 pixels per
// job) share stimulus; a scoreboard holds expected plaintext words.
module tb_rc4_decrypt_seq;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start4 = 1'b0, start6 = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word = '0;
  logic        ks_valid = 1'b0;
  logic [7:0]  ks_byte = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic [19:0] pix4, pix6;
  logic        busy4, busy6, done4, done6;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] word_tab[$];
  logic [7:0]  ks_tab[$];
  logic [31:0] sb[$];
  logic [31:0] last_out;

  always #5 clk = ~clk;

  rc4_decrypt_seq_if if4 ();
  rc4_decrypt_seq_if if6 ();

  function automatic logic [7:0] core_model(input logic [31:0] w, input logic [1:0] i,
                                            input logic [7:0] k);
    case (i)
      2'd0:    core_model = w[31:24] ^ k;
      2'd1:    core_model = w[23:16] ^ k;
      2'd2:    core_model = w[15:8]  ^ k;
      default: core_model = w[7:0]   ^ k;
    endcase
  endfunction

  assign if4.word_valid_i = word_valid;
  assign if4.word_i       = word;
  assign if4.ks_valid_i   = ks_valid;
  assign if4.ks_byte_i    = ks_byte;
  assign if4.out_ready_i  = out_ready;
  assign if4.core_data_i  = core_model(if4.core_word_o, if4.core_idx_o, if4.core_ks_o);
  assign if6.word_valid_i = word_valid;
  assign if6.word_i       = word;
  assign if6.ks_valid_i   = ks_valid;
  assign if6.ks_byte_i    = ks_byte;
  assign if6.out_ready_i  = out_ready;
  assign if6.core_data_i  = core_model(if6.core_word_o, if6.core_idx_o, if6.core_ks_o);

  rc4_decrypt_seq #(.PIXEL_COUNT(20'd4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start_i(start4), .bus(if4),
    .pix_num_o(pix4), .busy_o(busy4), .done_o(done4)
  );

  rc4_decrypt_seq #(.PIXEL_COUNT(20'd6)) u_dut6 (
    .clk(clk), .n_rst(n_rst), .start_i(start6), .bus(if6),
    .pix_num_o(pix6), .busy_o(busy6), .done_o(done6)
  );

  // View of whichever instance the current test drives.
  logic        word_ready, ks_req, core_xor, out_valid, busy, done;
  logic [1:0]  core_idx;
  logic [31:0] out_word;
  logic [19:0] pix_num;
  assign word_ready = sel ? if6.word_ready_o : if4.word_ready_o;
  assign ks_req     = sel ? if6.ks_req_o     : if4.ks_req_o;
  assign core_xor   = sel ? if6.core_xor_o   : if4.core_xor_o;
  assign core_idx   = sel ? if6.core_idx_o   : if4.core_idx_o;
  assign out_valid  = sel ? if6.out_valid_o  : if4.out_valid_o;
  assign out_word   = sel ? if6.out_word_o   : if4.out_word_o;
  assign pix_num    = sel ? pix6 : pix4;
  assign busy       = sel ? busy6 : busy4;
  assign done       = sel ? done6 : done4;

  // Runs one job on the selected instance, acting as reader, PRGA and writer.
  // Inputs are set on the falling edge for the following rising edge.
  task automatic run_job(input logic s, input int npix, input int ks_wait, input int out_wait,
                         input int start_pulse_cyc, input bit abort_idx2,
                         input logic [19:0] prev_pix);
    int cyc = 0, wi = 0, ki = 0, kw = 0, ow = 0, fetched = 0;
    int first_ready = -1, first_write = -1;
    bit ks_pend = 0, out_pend = 0, prev_xor = 0, done_seen = 0;
    logic [31:0] held, e, w;
    sel = s;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pix_num !== prev_pix)
      $display("FAIL idle_before_start: busy=%b done=%b pix=%0d, want 0 0 %0d",
               busy, done, pix_num, prev_pix);
    else n_pass++;
    if (s) start6 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start6 = 1'b0;
    while (!done_seen && cyc < 400) begin
      if (cyc == start_pulse_cyc) begin
        if (s) start6 = 1'b1; else start4 = 1'b1;
      end else begin
        start4 = 1'b0; start6 = 1'b0;
      end
      // word source: always offers a word so extra fetches would be visible
      word_valid = 1'b1;
      word = (wi < word_tab.size()) ? word_tab[wi] : 32'hDEAD_BEEF;
      if (word_ready) begin
        if (first_ready < 0) begin
          first_ready = cyc;
          n_checks++;
          if (pix_num !== 20'd0) $display("FAIL pix_start: got %0d want 0", pix_num);
          else n_pass++;
        end
        w = word;
        e = '0;
        for (int b = 0; b < 4; b++)
          if (4 * fetched + b < npix)
            e[31 - 8*b -: 8] = w[31 - 8*b -: 8] ^ ks_tab[4 * fetched + b];
        sb.push_back(e);
        fetched++;
        wi++;
      end
      // keystream source
      if (ks_pend) begin
        n_checks++;
        if (ks_req !== 1'b1) $display("FAIL ks_req_held: got %b want 1", ks_req);
        else n_pass++;
      end
      if (ks_req) begin
        if (kw < ks_wait) begin
          ks_valid = 1'b0; kw++; ks_pend = 1;
        end else begin
          ks_valid = 1'b1;
          ks_byte  = (ki < ks_tab.size()) ? ks_tab[ki] : 8'h00;
          ki++; kw = 0; ks_pend = 0;
        end
      end else begin
        ks_valid = 1'b1; ks_byte = 8'hA5;
      end
      // write stage
      if (out_pend) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_word !== held)
          $display("FAIL out_hold: valid=%b word=%h, want 1 %h", out_valid, out_word, held);
        else n_pass++;
      end
      if (out_valid) begin
        if (ow < out_wait) begin
          out_ready = 1'b0; ow++; out_pend = 1; held = out_word;
        end else begin
          out_ready = 1'b1; ow = 0; out_pend = 0;
          if (first_write < 0) first_write = cyc;
          last_out = out_word;
          n_checks++;
          if (sb.size() == 0) $display("FAIL out_word: got %h with nothing expected", out_word);
          else begin
            e = sb.pop_front();
            if (out_word !== e) $display("FAIL out_word: got %h want %h", out_word, e);
            else n_pass++;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (core_xor) begin
        n_checks++;
        if (prev_xor) $display("FAIL xor_one_cycle: strobe high 2 cycles idx=%0d", core_idx);
        else n_pass++;
        if (abort_idx2 && core_idx == 2'd2) return;
      end
      prev_xor = core_xor;
      if (done) begin
        done_seen = 1;
        n_checks++;
        if (pix_num !== 20'(npix)) $display("FAIL pix_final: got %0d want %0d", pix_num, npix);
        else n_pass++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start4 = 1'b0; start6 = 1'b0;
    n_checks++;
    if (!done_seen) $display("FAIL job_timeout: no done after %0d cycles", cyc);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0 || fetched != (npix + 3) / 4)
      $display("FAIL word_count: fetched %0d pending %0d, want %0d pending 0",
               fetched, sb.size(), (npix + 3) / 4);
    else n_pass++;
    if (ks_wait == 0 && out_wait == 0 && npix >= 4) begin
      n_checks++;
      if (first_write - first_ready + 1 != 10)
        $display("FAIL word_latency: got %0d cycles want 10", first_write - first_ready + 1);
      else n_pass++;
    end
  endtask

  task automatic load_hipi();
    word_tab = '{32'h48695069};
    ks_tab   = '{8'h37, 8'h29, 8'h2A, 8'h37};
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({if4.word_ready_o, if4.ks_req_o, if4.core_xor_o, if4.out_valid_o, busy4, done4,
         if6.word_ready_o, if6.ks_req_o, if6.core_xor_o, if6.out_valid_o, busy6, done6} !== 12'h0)
      $display("FAIL reset_strobes: some strobe not 0");
    else n_pass++;
    n_checks++;
    if ({if4.core_word_o, if4.core_ks_o, if4.core_idx_o, if4.out_word_o, pix4} !== '0)
      $display("FAIL reset_regs: word=%h ks=%h idx=%0d out=%h pix=%0d", if4.core_word_o,
               if4.core_ks_o, if4.core_idx_o, if4.out_word_o, pix4);
    else n_pass++;
    n_rst = 1'b1;
  endtask

  task automatic test_basic();
    load_hipi();
    run_job(1'b0, 4, 0, 0, -1, 1'b0, 20'd0);
    n_checks++;
    if (last_out !== 32'h7F407A5E) $display("FAIL hipi_word: got %h want 7f407a5e", last_out);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    load_hipi();
    run_job(1'b0, 4, 3, 5, -1, 1'b0, 20'd4);
    n_checks++;
    if (last_out !== 32'h7F407A5E) $display("FAIL bp_word: got %h want 7f407a5e", last_out);
    else n_pass++;
  endtask

  task automatic test_partial();
    word_tab = '{32'h48695069, 32'h41424344};
    ks_tab   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_job(1'b1, 6, 0, 0, -1, 1'b0, 20'd0);
    n_checks++;
    if (last_out !== 32'h41420000) $display("FAIL partial_word: got %h want 41420000", last_out);
    else n_pass++;
  endtask

  task automatic test_ignored();
    load_hipi();
    run_job(1'b0, 4, 0, 0, 4, 1'b0, 20'd4);
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0) $display("FAIL start_ignored: busy=%b want 0 after job", busy4);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_hipi();
    run_job(1'b0, 4, 0, 0, -1, 1'b1, 20'd4);
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({if4.word_ready_o, if4.ks_req_o, if4.core_xor_o, if4.out_valid_o, busy4, done4} !== 6'h0)
      $display("FAIL midreset_strobes: xor=%b busy=%b", if4.core_xor_o, busy4);
    else n_pass++;
    n_checks++;
    if ({if4.core_word_o, if4.core_ks_o, if4.core_idx_o, if4.out_word_o, pix4} !== '0)
      $display("FAIL midreset_regs: word=%h ks=%h idx=%0d out=%h pix=%0d", if4.core_word_o,
               if4.core_ks_o, if4.core_idx_o, if4.out_word_o, pix4);
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0) $display("FAIL no_autostart: busy=%b want 0", busy4);
    else n_pass++;
    run_job(1'b0, 4, 0, 0, -1, 1'b0, 20'd0);
  endtask

  task automatic test_back_to_back();
    word_tab = '{$urandom(), $urandom()};
    ks_tab.delete();
    for (int i = 0; i < 6; i++) ks_tab.push_back(8'($urandom_range(255)));
    run_job(1'b1, 6, 0, 0, -1, 1'b0, 20'd0);
    run_job(1'b1, 6, 1, 2, -1, 1'b0, 20'd6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_partial();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
